// File: rtl/switch_xfer_sched.sv
// switch_xfer_sched: all-or-nothing round-robin session scheduler for a 4-port crossbar
//   clk, rst_n (async, active-low)
//   req_valid/req_dst0..3/req_len0..3 : per-input packet header (output mask, beats-1)
//   beat_valid : per-input data beat strobe
//   req_ready/xfer_done : one-cycle session start/finish pulses
//   out_en/out_sel0..3  : registered output mux enables and selects
//   Optional SWITCH_XFER_SCHED_AGING_EN: age counters reserve outputs for a starved request
module switch_xfer_sched #(
   parameter int LEN_W   = 8,
   parameter int AGE_MAX = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req_valid,
   input  logic [3:0]       req_dst0,
   input  logic [3:0]       req_dst1,
   input  logic [3:0]       req_dst2,
   input  logic [3:0]       req_dst3,
   input  logic [LEN_W-1:0] req_len0,
   input  logic [LEN_W-1:0] req_len1,
   input  logic [LEN_W-1:0] req_len2,
   input  logic [LEN_W-1:0] req_len3,
   input  logic [3:0]       beat_valid,
   output logic [3:0]       req_ready,
   output logic [3:0]       xfer_done,
   output logic [3:0]       out_en,
   output logic [1:0]       out_sel0,
   output logic [1:0]       out_sel1,
   output logic [1:0]       out_sel2,
   output logic [1:0]       out_sel3
);
   typedef enum logic {IDLE, XFER} state_t;
   state_t           state [4], state_nxt [4];
   logic [LEN_W-1:0] rem [4], rem_nxt [4];
   logic [1:0]       owner [4], owner_nxt [4];
   logic [3:0]       locked, locked_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [3:0]       ready_nxt, done_nxt;
   logic [3:0]       dst [4];
   logic [LEN_W-1:0] len [4];
   logic [3:0]       elig, rsv;
   logic             gnt;
   logic [1:0]       win, idx;
`ifdef SWITCH_XFER_SCHED_AGING_EN
   localparam int AGE_W = $clog2(AGE_MAX + 1);
   logic [AGE_W-1:0] age [4], age_nxt [4];
   logic             sen_v;
   logic [1:0]       sen;
`endif
   assign dst[0] = req_dst0;
   assign dst[1] = req_dst1;
   assign dst[2] = req_dst2;
   assign dst[3] = req_dst3;
   assign len[0] = req_len0;
   assign len[1] = req_len1;
   assign len[2] = req_len2;
   assign len[3] = req_len3;
   assign out_en   = locked;
   assign out_sel0 = owner[0];
   assign out_sel1 = owner[1];
   assign out_sel2 = owner[2];
   assign out_sel3 = owner[3];
   // Arbitration uses registered lock state only, so an output freed this cycle waits one cycle.
   always_comb begin
      for (int i = 0; i < 4; i++) elig[i] = state[i] == IDLE && req_valid[i] && dst[i] != 4'b0;
      rsv = '0;
      gnt = 1'b0;
      win = ptr;
      idx = '0;
`ifdef SWITCH_XFER_SCHED_AGING_EN
      sen_v = 1'b0;
      sen   = ptr;
      for (int j = 0; j < 4; j++) begin
         idx = ptr + 2'(j);
         if (!sen_v && elig[idx] && age[idx] == AGE_W'(AGE_MAX)) begin
            sen_v = 1'b1;
            sen   = idx;
         end
      end
      // The senior's outputs are reserved; it wins the moment they are all free.
      if (sen_v) begin
         rsv = dst[sen];
         if ((dst[sen] & locked) == 4'b0) begin
            gnt = 1'b1;
            win = sen;
         end
      end
`endif
      for (int j = 0; j < 4; j++) begin
         idx = ptr + 2'(j);
         if (!gnt && elig[idx] && (dst[idx] & (locked | rsv)) == 4'b0) begin
            gnt = 1'b1;
            win = idx;
         end
      end
   end
   always_comb begin
      state_nxt  = state;
      rem_nxt    = rem;
      owner_nxt  = owner;
      locked_nxt = locked;
      ptr_nxt    = ptr;
      ready_nxt  = '0;
      done_nxt   = '0;
      for (int i = 0; i < 4; i++) begin
         if (state[i] == XFER && beat_valid[i]) begin
            if (rem[i] != '0) rem_nxt[i] = rem[i] - 1'b1;
            else begin
               state_nxt[i] = IDLE;
               done_nxt[i]  = 1'b1;
               for (int k = 0; k < 4; k++) begin
                  if (locked[k] && owner[k] == 2'(i)) begin
                     locked_nxt[k] = 1'b0;
                     owner_nxt[k]  = '0;
                  end
               end
            end
         end
      end
      // Grant only touches unlocked outputs, so it never collides with a release above.
      if (gnt) begin
         state_nxt[win] = XFER;
         rem_nxt[win]   = len[win];
         ready_nxt[win] = 1'b1;
         ptr_nxt        = win + 2'd1;
         for (int k = 0; k < 4; k++) begin
            if (dst[win][k]) begin
               locked_nxt[k] = 1'b1;
               owner_nxt[k]  = win;
            end
         end
      end
`ifdef SWITCH_XFER_SCHED_AGING_EN
      for (int i = 0; i < 4; i++)
         age_nxt[i] = (!elig[i] || (gnt && win == 2'(i))) ? '0 :
                      (age[i] == AGE_W'(AGE_MAX)) ? age[i] : age[i] + 1'b1;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            state[i] <= IDLE;
            rem[i]   <= '0;
            owner[i] <= '0;
`ifdef SWITCH_XFER_SCHED_AGING_EN
            age[i]   <= '0;
`endif
         end
         locked    <= '0;
         ptr       <= '0;
         req_ready <= '0;
         xfer_done <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state[i] <= state_nxt[i];
            rem[i]   <= rem_nxt[i];
            owner[i] <= owner_nxt[i];
`ifdef SWITCH_XFER_SCHED_AGING_EN
            age[i]   <= age_nxt[i];
`endif
         end
         locked    <= locked_nxt;
         ptr       <= ptr_nxt;
         req_ready <= ready_nxt;
         xfer_done <= done_nxt;
      end
   end
endmodule

// File: tb/tb_switch_xfer_sched.sv
// tb_switch_xfer_sched: directed self-checking bench for switch_xfer_sched (default build)
module tb_switch_xfer_sched;
   localparam int LEN_W = 8;
   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       req_valid, beat_valid;
   logic [3:0]       req_dst0, req_dst1, req_dst2, req_dst3;
   logic [LEN_W-1:0] req_len0, req_len1, req_len2, req_len3;
   logic [3:0]       req_ready, xfer_done, out_en;
   logic [1:0]       out_sel0, out_sel1, out_sel2, out_sel3;
   int               total = 0;
   int               bad = 0;
   logic [3:0]       rr_exp [8];

   switch_xfer_sched #(.LEN_W(LEN_W), .AGE_MAX(15)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
      .req_dst0(req_dst0), .req_dst1(req_dst1), .req_dst2(req_dst2), .req_dst3(req_dst3),
      .req_len0(req_len0), .req_len1(req_len1), .req_len2(req_len2), .req_len3(req_len3),
      .beat_valid(beat_valid), .req_ready(req_ready), .xfer_done(xfer_done), .out_en(out_en),
      .out_sel0(out_sel0), .out_sel1(out_sel1), .out_sel2(out_sel2), .out_sel3(out_sel3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      req_valid = '0; beat_valid = '0;
      req_dst0 = '0; req_dst1 = '0; req_dst2 = '0; req_dst3 = '0;
      req_len0 = '0; req_len1 = '0; req_len2 = '0; req_len3 = '0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   initial begin
      rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
      // reset state
      do_reset;
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_done", {28'd0, xfer_done}, 32'd0);
      chk("rst_en", {28'd0, out_en}, 32'd0);
      chk("rst_sel", {24'd0, out_sel3, out_sel2, out_sel1, out_sel0}, 32'd0);
      // single unicast: 4 beats on output 1
      req_valid = 4'b0001; req_dst0 = 4'b0010; req_len0 = 8'd3; beat_valid = 4'b0001;
      tick;
      chk("u_ready", {28'd0, req_ready}, 32'h1);
      chk("u_en", {28'd0, out_en}, 32'h2);
      chk("u_sel1", {30'd0, out_sel1}, 32'h0);
      req_valid = '0;
      for (int c = 2; c <= 4; c++) begin
         tick;
         chk("u_hold_en", {28'd0, out_en}, 32'h2);
         chk("u_nodone", {28'd0, xfer_done}, 32'h0);
      end
      tick;
      chk("u_done", {28'd0, xfer_done}, 32'h1);
      chk("u_clr", {28'd0, out_en}, 32'h0);
      beat_valid = '0;
      tick;
      chk("u_done_pulse", {28'd0, xfer_done}, 32'h0);
      // round-robin on output 0, 1-beat packets
      do_reset;
      req_valid = 4'hF; beat_valid = 4'hF;
      req_dst0 = 4'b0001; req_dst1 = 4'b0001; req_dst2 = 4'b0001; req_dst3 = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         tick;
         chk("rr_ready", {28'd0, req_ready}, {28'd0, rr_exp[c]});
         if (c == 6) chk("rr_sel0", {30'd0, out_sel0}, 32'd3);
         req_valid = req_valid & ~req_ready;
      end
      req_valid = 4'b0011;
      tick;
      chk("rr_wrap", {28'd0, req_ready}, 32'h1);
      req_valid = '0;
      tick;
      // disjoint parallel sessions
      do_reset;
      req_valid = 4'b0110; req_dst1 = 4'b0100; req_dst2 = 4'b1000; req_len1 = 8'd5; req_len2 = 8'd5;
      tick;
      chk("dj_ready1", {28'd0, req_ready}, 32'h2);
      chk("dj_en1", {28'd0, out_en}, 32'h4);
      req_valid = 4'b0100;
      tick;
      chk("dj_ready2", {28'd0, req_ready}, 32'h4);
      chk("dj_en2", {28'd0, out_en}, 32'hC);
      chk("dj_sel2", {30'd0, out_sel2}, 32'd1);
      chk("dj_sel3", {30'd0, out_sel3}, 32'd2);
      req_valid = '0; beat_valid = 4'b0110;
      for (int c = 1; c <= 5; c++) begin
         tick;
         chk("dj_nodone", {28'd0, xfer_done}, 32'h0);
      end
      tick;
      chk("dj_done", {28'd0, xfer_done}, 32'h6);
      chk("dj_clr", {28'd0, out_en}, 32'h0);
      chk("dj_sel_clr", {24'd0, out_sel3, out_sel2, out_sel1, out_sel0}, 32'd0);
      beat_valid = '0;
      // multicast waits for output 0 held by a 20-beat session
      do_reset;
      req_valid = 4'b1000; req_dst3 = 4'b0001; req_len3 = 8'd19;
      tick;
      chk("mc_ready3", {28'd0, req_ready}, 32'h8);
      req_valid = 4'b0001; req_dst0 = 4'b0011; req_len0 = 8'd0; beat_valid = 4'b1000;
      tick;
      for (int c = 2; c <= 20; c++) begin
         chk("mc_wait_ready", {28'd0, req_ready}, 32'h0);
         chk("mc_wait_en", {28'd0, out_en}, 32'h1);
         tick;
      end
      chk("mc_done3", {28'd0, xfer_done}, 32'h8);
      chk("mc_gap_en", {28'd0, out_en}, 32'h0);
      chk("mc_gap_ready", {28'd0, req_ready}, 32'h0);
      tick;
      chk("mc_ready0", {28'd0, req_ready}, 32'h1);
      chk("mc_en", {28'd0, out_en}, 32'h3);
      req_valid = '0; beat_valid = 4'b0001;
      tick;
      chk("mc_done0", {28'd0, xfer_done}, 32'h1);
      beat_valid = '0;
      // reset mid-session
      do_reset;
      req_valid = 4'b0100; req_dst2 = 4'b0100; req_len2 = 8'd5; beat_valid = 4'b0100;
      tick;
      chk("rs_ready", {28'd0, req_ready}, 32'h4);
      chk("rs_en", {28'd0, out_en}, 32'h4);
      req_valid = '0;
      tick;
      rst_n = 1'b0;
      #1;
      chk("rs_async_en", {28'd0, out_en}, 32'h0);
      chk("rs_async_sel", {24'd0, out_sel3, out_sel2, out_sel1, out_sel0}, 32'd0);
      tick;
      chk("rs_nodone", {28'd0, xfer_done}, 32'h0);
      tick;
      rst_n = 1'b1; beat_valid = '0;
      req_valid = 4'b0010; req_dst1 = 4'b0010; req_len1 = 8'd0;
      tick;
      chk("rs_fresh_ready", {28'd0, req_ready}, 32'h2);
      chk("rs_fresh_en", {28'd0, out_en}, 32'h2);
      chk("rs_fresh_sel1", {30'd0, out_sel1}, 32'd1);
      // zero mask never granted; max length carries 256 beats
      do_reset;
      req_valid = 4'b1010; req_dst3 = 4'b0000; req_dst1 = 4'b0001; req_len1 = 8'd255; beat_valid = 4'b0010;
      tick;
      chk("wr_ready", {28'd0, req_ready}, 32'h2);
      req_valid = 4'b1000;
      for (int c = 1; c <= 255; c++) tick;
      chk("wr_nodone", {28'd0, xfer_done}, 32'h0);
      chk("wr_mask0", {28'd0, req_ready}, 32'h0);
      tick;
      chk("wr_done", {28'd0, xfer_done}, 32'h2);
      chk("wr_clr", {28'd0, out_en}, 32'h0);
      req_valid = '0; beat_valid = '0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
